// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree classifier: walks a programmable node table one node per clock from root 0.
// Latency d+1 cycles after accept for d internal nodes; holds the result in DONE until out_ready; no overlap.
module dtree_seq_eval #(
    parameter int NUM_FEAT  = 18,
    parameter int FEAT_W    = 8,
    parameter int NODE_AW   = 7,
    parameter int CLASS_W   = 2,
    parameter int MAX_DEPTH = 16,
    localparam int FI_W     = $clog2(NUM_FEAT),
    localparam int PREC_W   = $clog2(FEAT_W),
    localparam int NODE_W   = 1 + FI_W + PREC_W + FEAT_W + 2*NODE_AW,
    localparam int DEP_W    = $clog2(MAX_DEPTH+1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_FEAT*FEAT_W-1:0] in_feat,
    input  logic                       cfg_we,
    input  logic [NODE_AW-1:0]         cfg_addr,
    input  logic [NODE_W-1:0]          cfg_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLASS_W-1:0]         out_class,
    output logic [DEP_W-1:0]           out_depth,
    output logic                       out_err
);
    localparam int NNODES = 2**NODE_AW;
    localparam int SHW    = PREC_W + 1;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t                      state_q, state_d;
    logic [NODE_W-1:0]           nodes [NNODES];
    logic [NUM_FEAT*FEAT_W-1:0]  feat_q;
    logic [NODE_AW-1:0]          cur_q;
    logic [DEP_W-1:0]            cnt_q;
    logic [CLASS_W-1:0]          class_q;
    logic [DEP_W-1:0]            depth_q;
    logic                        err_q;

    logic [NODE_W-1:0]           node;
    logic                        n_leaf;
    logic [FI_W-1:0]             n_fidx;
    logic [PREC_W-1:0]           n_pm1;
    logic [FEAT_W-1:0]           n_thr;
    logic [NODE_AW-1:0]          n_left, n_right;
    logic [FEAT_W-1:0]           feat_sel, v;
    logic [SHW-1:0]              shamt;
    logic [DEP_W-1:0]            cnt_inc;
    logic                        fidx_bad, depth_hit, go_left;

    assign node = nodes[cur_q];
    assign {n_leaf, n_fidx, n_pm1, n_thr, n_left, n_right} = node;

    always_comb begin
        feat_sel = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (n_fidx == FI_W'(k)) feat_sel = feat_q[k*FEAT_W +: FEAT_W];
        end
    end

    // Keep the top p bits of the feature: shift right by FEAT_W-p = FEAT_W-1-pm1.
    assign shamt     = SHW'(FEAT_W-1) - {1'b0, n_pm1};
    assign v         = feat_sel >> shamt;
    assign go_left   = (v <= n_thr);
    assign cnt_inc   = cnt_q + DEP_W'(1);
    assign fidx_bad  = (32'(n_fidx) >= NUM_FEAT);
    assign depth_hit = (cnt_inc == DEP_W'(MAX_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = WALK;
            WALK:    if (n_leaf || fidx_bad || depth_hit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_class = class_q;
    assign out_depth = depth_q;
    assign out_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q  <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            class_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        feat_q <= in_feat;
                        cur_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                WALK: begin
                    cnt_q <= cnt_inc;
                    if (n_leaf) begin
                        class_q <= n_thr[CLASS_W-1:0];
                        depth_q <= cnt_inc;
                        err_q   <= 1'b0;
                    end else if (fidx_bad || depth_hit) begin
                        class_q <= '0;
                        depth_q <= cnt_inc;
                        err_q   <= 1'b1;
                    end else begin
                        cur_q <= go_left ? n_left : n_right;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table writes land only while idle, so a walk never sees a half-updated tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NNODES; i++) nodes[i] <= {1'b1, {(NODE_W-1){1'b0}}};
        end else if (state_q == IDLE && cfg_we) begin
            nodes[cfg_addr] <= cfg_wdata;
        end
    end
endmodule

// File: tb/tb_dtree_seq_eval.sv
// Directed bench for dtree_seq_eval: hand-built node tables and vectors with hand-computed results.
module tb_dtree_seq_eval;
    localparam int NF = 18, FW = 8, AW = 7, CW = 2, MD = 16;
    localparam int NW = 31, DW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready;
    logic [NF*FW-1:0]  in_feat;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [NW-1:0]     cfg_wdata;
    logic              out_valid, out_ready;
    logic [CW-1:0]     out_class;
    logic [DW-1:0]     out_depth;
    logic              out_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc    = 0;

    dtree_seq_eval dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_depth(out_depth), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NW-1:0] nd(input logic [4:0] fidx, input logic [2:0] pm1,
                                         input logic [7:0] thr, input logic [6:0] l, input logic [6:0] r);
        return {1'b0, fidx, pm1, thr, l, r};
    endfunction

    function automatic logic [NW-1:0] leaf(input logic [1:0] cls);
        return {1'b1, 5'd0, 3'd0, 6'd0, cls, 14'd0};
    endfunction

    function automatic logic [NF*FW-1:0] fv(input int idx, input logic [7:0] val);
        logic [NF*FW-1:0] f;
        f = '0;
        f[idx*FW +: FW] = val;
        return f;
    endfunction

    task automatic cfg_write(input logic [AW-1:0] a, input logic [NW-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Drives one vector; returns at the first negedge after the accepting edge.
    task automatic start_vec(input string tag, input logic [NF*FW-1:0] f);
        @(negedge clk);
        check({tag, "_in_ready_before"}, in_ready, 1);
        in_valid = 1'b1; in_feat = f;
        @(negedge clk);
        in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_result(input string tag, input int cls, input int dep, input int err);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, cyc - acc, dep);
        check({tag, "_class"}, out_class, cls);
        check({tag, "_depth"}, out_depth, dep);
        check({tag, "_err"}, out_err, err);
        check({tag, "_in_ready_busy"}, in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    task automatic run(input string tag, input logic [NF*FW-1:0] f, input int cls, input int dep, input int err);
        start_vec(tag, f);
        wait_result(tag, cls, dep, err);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        #22 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_class", out_class, 0);
        check("rst_depth", out_depth, 0);
        check("rst_err", out_err, 0);

        run("unprog", fv(5, 8'hC3), 0, 1, 0);

        cfg_write(0, nd(7, 3, 9, 1, 2));
        cfg_write(1, leaf(1));
        cfg_write(2, leaf(2));
        run("x7_9f", fv(7, 8'h9F), 1, 2, 0);
        run("x7_a0", fv(7, 8'hA0), 2, 2, 0);

        // Precision boundaries on feature 3.
        cfg_write(0, nd(3, 7, 8'h80, 1, 2));
        run("p8_eq", fv(3, 8'h80), 1, 2, 0);
        run("p8_gt", fv(3, 8'h81), 2, 2, 0);
        cfg_write(0, nd(3, 0, 8'h00, 1, 2));
        run("p1_lo", fv(3, 8'h7F), 1, 2, 0);
        run("p1_hi", fv(3, 8'h80), 2, 2, 0);
        cfg_write(0, nd(3, 0, 8'h02, 1, 2));
        run("thr_big", fv(3, 8'hFF), 1, 2, 0);

        cfg_write(0, nd(0, 7, 8'h00, 0, 0));
        run("selfloop", '0, 0, MD, 1);
        cfg_write(0, nd(31, 7, 8'h00, 1, 2));
        run("fidx31", '0, 0, 1, 1);
        cfg_write(0, nd(18, 7, 8'h00, 1, 2));
        run("fidx18", '0, 0, 1, 1);

        // Hold the result for 5 cycles while a new vector is offered.
        cfg_write(0, nd(7, 3, 9, 1, 2));
        start_vec("hold", fv(7, 8'h00));
        while (!out_valid && cyc - acc < 40) @(negedge clk);
        in_valid = 1'b1; in_feat = fv(7, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_class", out_class, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_idle_valid", out_valid, 0);
        check("b2b_idle_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        acc = cyc;
        check("b2b_accepted", in_ready, 0);
        wait_result("b2b", 2, 2, 0);

        // A write while walking must be dropped.
        start_vec("walkcfg", fv(7, 8'h00));
        cfg_we = 1'b1; cfg_addr = 1; cfg_wdata = leaf(3);
        @(negedge clk);
        cfg_we = 1'b0;
        wait_result("walkcfg", 1, 2, 0);
        run("after_walkcfg", fv(7, 8'h00), 1, 2, 0);

        // A write on the accepting edge is visible to that walk.
        @(negedge clk);
        in_valid = 1'b1; in_feat = fv(7, 8'h00);
        cfg_we = 1'b1; cfg_addr = 1; cfg_wdata = leaf(3);
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
        acc = cyc;
        wait_result("acc_cfg", 3, 2, 0);

        // Depth-5 chain, then reset mid-walk.
        for (int k = 0; k < 4; k++) cfg_write(7'(k), nd(0, 7, 8'hFF, 7'(k+1), 7'(k+1)));
        cfg_write(4, leaf(3));
        run("chain5", '0, 3, 5, 0);
        start_vec("rstwalk", '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstwalk_in_ready", in_ready, 1);
        check("rstwalk_valid", out_valid, 0);
        check("rstwalk_class", out_class, 0);
        check("rstwalk_depth", out_depth, 0);
        check("rstwalk_err", out_err, 0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rstwalk_no_pulse", seen, 0);
        run("table_reverted", '0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
